// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the fetch FSM encoding, the bubble word and the PC alignment helper.
package fetch_pkg;

  localparam int PC_W = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    SKID  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// The fetch stage is the master; the memory answers with ack and rdata.
interface fetch_unit_if;
  import fetch_pkg::*;

  logic            imem_req_o;
  logic [PC_W-1:0] imem_addr_o;
  logic            imem_ack_i;
  logic [31:0]     imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ack_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ack_i,
    output imem_rdata_i
  );

endinterface

// File: rtl/fetch_skid_reg.sv
// One-entry pc/instruction holding register for responses that arrive while ID stalls.
// Clear wins over load so a redirect always flushes the entry.
module fetch_skid_reg
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic [PC_W-1:0] load_pc,
  input  logic [31:0]     load_instr,
  output logic            valid,
  output logic [PC_W-1:0] pc,
  output logic [31:0]     instr
);

  // Entry storage: flushed by clear, captured by load, otherwise held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= NOP_INSTR;
    end else if (clear) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= NOP_INSTR;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end else begin
      valid <= valid;
      pc    <= pc;
      instr <= instr;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks req/ack to imem, applies redirects
// and presents pc_out/instruction to IF/ID, with a skid entry for stalled responses.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [PC_W-1:0] PC_STEP  = 32'd4
) (
  input  logic              clk,
  input  logic              rst,
  fetch_unit_if.master      imem,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [PC_W-1:0]   redirect_pc_i,
  output logic [PC_W-1:0]   pc_out,
  output logic [31:0]       instruction,
  output logic              fetch_valid
);

  fetch_state_e    state_r;
  logic [PC_W-1:0] fetch_pc_r;
  logic [PC_W-1:0] drain_addr_r;
  logic            slot_free_s;
  logic [PC_W-1:0] target_s;
  logic            skid_load_s;
  logic            skid_clear_s;
  logic            skid_valid_s;
  logic [PC_W-1:0] skid_pc_s;
  logic [31:0]     skid_instr_s;

  assign slot_free_s = !fetch_valid || !stall_i;
  assign target_s    = word_align(redirect_pc_i);

  // Request drive; DRAIN keeps presenting the abandoned address until it is acked.
  always_comb begin
    imem.imem_req_o  = 1'b0;
    imem.imem_addr_o = fetch_pc_r;
    case (state_r)
      FETCH: begin
        imem.imem_req_o  = !rst;
        imem.imem_addr_o = fetch_pc_r;
      end
      SKID: begin
        imem.imem_req_o  = 1'b0;
        imem.imem_addr_o = fetch_pc_r;
      end
      DRAIN: begin
        imem.imem_req_o  = !rst;
        imem.imem_addr_o = drain_addr_r;
      end
      default: begin
        imem.imem_req_o  = 1'b0;
        imem.imem_addr_o = fetch_pc_r;
      end
    endcase
  end

  // Skid control: redirect flushes, a released stall empties, a busy-slot ack fills.
  always_comb begin
    skid_load_s  = 1'b0;
    skid_clear_s = 1'b0;
    if (redirect_i) begin
      skid_clear_s = 1'b1;
    end else if (state_r == SKID && !stall_i) begin
      skid_clear_s = 1'b1;
    end else if (state_r == FETCH && imem.imem_ack_i && !slot_free_s) begin
      skid_load_s = 1'b1;
    end else begin
      skid_load_s  = 1'b0;
      skid_clear_s = 1'b0;
    end
  end

  fetch_skid_reg u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load_s),
    .clear      (skid_clear_s),
    .load_pc    (fetch_pc_r),
    .load_instr (imem.imem_rdata_i),
    .valid      (skid_valid_s),
    .pc         (skid_pc_s),
    .instr      (skid_instr_s)
  );

  // Fetch FSM with the IF/ID-facing outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= FETCH;
      fetch_pc_r   <= RESET_PC;
      drain_addr_r <= '0;
      pc_out       <= '0;
      instruction  <= NOP_INSTR;
      fetch_valid  <= 1'b0;
    end else if (redirect_i) begin
      fetch_pc_r  <= target_s;
      pc_out      <= '0;
      instruction <= NOP_INSTR;
      fetch_valid <= 1'b0;
      case (state_r)
        FETCH: begin
          if (imem.imem_ack_i) begin
            state_r <= FETCH;
          end else begin
            state_r      <= DRAIN;
            drain_addr_r <= fetch_pc_r;
          end
        end
        SKID:    state_r <= FETCH;
        DRAIN:   state_r <= imem.imem_ack_i ? FETCH : DRAIN;
        default: state_r <= FETCH;
      endcase
    end else begin
      case (state_r)
        FETCH: begin
          if (imem.imem_ack_i) begin
            fetch_pc_r <= fetch_pc_r + PC_STEP;
            if (slot_free_s) begin
              pc_out      <= fetch_pc_r;
              instruction <= imem.imem_rdata_i;
              fetch_valid <= 1'b1;
            end else begin
              state_r <= SKID;
            end
          end else if (slot_free_s) begin
            instruction <= NOP_INSTR;
            fetch_valid <= 1'b0;
          end
        end
        SKID: begin
          if (!stall_i) begin
            pc_out      <= skid_pc_s;
            instruction <= skid_instr_s;
            fetch_valid <= skid_valid_s;
            state_r     <= FETCH;
          end
        end
        DRAIN: begin
          // The drained word belongs to the old path and is dropped.
          if (imem.imem_ack_i) begin
            state_r <= FETCH;
          end
        end
        default: state_r <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized stall/redirect/latency,
// checked against an in-order instruction-stream model and handshake rules.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redirect;
  logic [31:0] redirect_pc;
  logic        ack;
  logic [31:0] rdata;
  logic [31:0] pc_out, instruction;
  logic        fv;
  logic        zero_s;
  logic [31:0] zero_pc;
  logic [31:0] pc2, ins2;
  logic        fv2;

  int n_chk = 0;
  int n_pass = 0;
  int lat = 0;
  int wcnt = 0;
  bit rand_lat = 1'b0;
  int n_new = 0;

  // Stream model state
  logic [31:0] exp_pc;
  bit          prev_hold, prev_redirect, prev_wait;
  logic [31:0] prev_pc, prev_ins, prev_addr, redir_target;

  fetch_unit_if mem_if ();
  fetch_unit_if mem2_if ();

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ({a[15:0], a[31:16]} ^ 32'hC0DE_0000) | 32'h0000_0001;
  endfunction

  assign mem_if.imem_ack_i    = ack;
  assign mem_if.imem_rdata_i  = rdata;
  assign mem2_if.imem_ack_i   = mem2_if.imem_req_o;
  assign mem2_if.imem_rdata_i = mem_word(mem2_if.imem_addr_o);
  assign zero_s  = 1'b0;
  assign zero_pc = 32'h0000_0000;

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem(mem_if), .stall_i(stall), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .pc_out(pc_out), .instruction(instruction), .fetch_valid(fv)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst), .imem(mem2_if), .stall_i(zero_s), .redirect_i(zero_s),
    .redirect_pc_i(zero_pc), .pc_out(pc2), .instruction(ins2), .fetch_valid(fv2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Observe outputs on the negedge and compare with the stream model.
  task automatic tick();
    @(negedge clk);
    if (prev_redirect) begin
      chk("redir_valid", {31'd0, fv}, 32'd0);
      chk("redir_pc", pc_out, 32'd0);
      chk("redir_ins", instruction, 32'd0);
      exp_pc = redir_target;
    end else if (prev_hold) begin
      chk("hold_valid", {31'd0, fv}, 32'd1);
      chk("hold_pc", pc_out, prev_pc);
      chk("hold_ins", instruction, prev_ins);
    end else if (fv) begin
      chk("seq_pc", pc_out, exp_pc);
      chk("seq_ins", instruction, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      n_new++;
    end
    if (!fv) chk("bubble_zero", instruction, 32'd0);
    if (prev_wait) begin
      chk("req_held", {31'd0, mem_if.imem_req_o}, 32'd1);
      chk("addr_stable", mem_if.imem_addr_o, prev_addr);
    end
  endtask

  // Memory response for this cycle, then remember what the model needs next cycle.
  task automatic drive();
    #1;
    if (mem_if.imem_req_o) begin
      if (wcnt >= lat) begin
        ack = 1'b1;
        rdata = mem_word(mem_if.imem_addr_o);
        wcnt = 0;
        if (rand_lat) lat = $urandom_range(0, 3);
      end else begin
        ack = 1'b0;
        rdata = $urandom;
        wcnt++;
      end
    end else begin
      ack = 1'b0;
      rdata = $urandom;
    end
    prev_hold     = fv && stall && !redirect;
    prev_pc       = pc_out;
    prev_ins      = instruction;
    prev_redirect = redirect;
    redir_target  = {redirect_pc[31:2], 2'b00};
    prev_wait     = mem_if.imem_req_o && !ack;
    prev_addr     = mem_if.imem_addr_o;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'd0;
    ack = 1'b0;
    rdata = 32'd0;
    wcnt = 0;
    repeat (2) @(negedge clk);
    exp_pc = 32'd0;
    prev_hold = 1'b0;
    prev_redirect = 1'b0;
    prev_wait = 1'b0;
    rst = 1'b0;
    drive();
  endtask

  task automatic quiet_cycle();
    stall = 1'b0;
    redirect = 1'b0;
    drive();
  endtask

  initial begin
    logic [31:0] wrap_exp [3];
    bit found;
    int nv, npair;
    bit last_fv;

    wrap_exp[0] = 32'hFFFF_FFF8;
    wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000;
    rst = 1'b1;
    #1;
    chk("rst_valid", {31'd0, fv}, 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_ins", instruction, 32'd0);
    chk("rst_req", {31'd0, mem_if.imem_req_o}, 32'd0);

    // Zero-wait streaming from reset, plus the wrapping second instance.
    lat = 0;
    rand_lat = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("zw_valid", {31'd0, fv}, 32'd1);
      chk("zw_pc", pc_out, 32'(i * 4));
      if (i < 3) begin
        chk("wrap_valid", {31'd0, fv2}, 32'd1);
        chk("wrap_pc", pc2, wrap_exp[i]);
        chk("wrap_ins", ins2, mem_word(wrap_exp[i]));
      end
      quiet_cycle();
    end

    // Stall while pc 8 is presented and pc 12 is being acked.
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (fv && pc_out == 32'd8) found = 1'b1;
      else quiet_cycle();
    end
    chk("stall_reach", {31'd0, found}, 32'd1);
    stall = 1'b1;
    drive();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", pc_out, 32'd8);
      chk("skid_req", {31'd0, mem_if.imem_req_o}, 32'd0);
      stall = (i < 2);
      drive();
    end
    tick();
    chk("skid_out_pc", pc_out, 32'd12);
    quiet_cycle();
    tick();
    chk("after_skid_pc", pc_out, 32'd16);
    quiet_cycle();

    // Two-cycle memory: one valid cycle then two bubbles.
    lat = 2;
    do_reset();
    for (int i = 0; i < 6; i++) begin tick(); quiet_cycle(); end
    nv = 0;
    npair = 0;
    last_fv = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (fv) nv++;
      if (fv && last_fv) npair++;
      last_fv = fv;
      quiet_cycle();
    end
    chk("lat2_valids", 32'(nv), 32'd4);
    chk("lat2_b2b", 32'(npair), 32'd0);

    // Redirect to 0x103 while the request for 0x20 waits for its ack.
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      if (mem_if.imem_req_o && mem_if.imem_addr_o == 32'h20 && wcnt == 0) found = 1'b1;
      else quiet_cycle();
    end
    chk("drain_reach", {31'd0, found}, 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    drive();
    tick();
    chk("drain_addr", mem_if.imem_addr_o, 32'h20);
    quiet_cycle();
    tick();
    quiet_cycle();
    tick();
    chk("redir_req_addr", mem_if.imem_addr_o, 32'h100);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (fv) found = 1'b1;
      else begin quiet_cycle(); tick(); end
    end
    chk("redir_first_valid", {31'd0, found}, 32'd1);
    chk("redir_first_pc", pc_out, 32'h100);
    quiet_cycle();

    // Redirect while the skid entry is full and ID keeps stalling.
    lat = 0;
    do_reset();
    tick();
    stall = 1'b1;
    drive();
    tick();
    chk("skid_entered", {31'd0, mem_if.imem_req_o}, 32'd0);
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0400;
    drive();
    tick();
    chk("skid_flush_valid", {31'd0, fv}, 32'd0);
    stall = 1'b1;
    redirect = 1'b0;
    drive();
    tick();
    chk("skid_redir_valid", {31'd0, fv}, 32'd1);
    chk("skid_redir_pc", pc_out, 32'h400);
    quiet_cycle();

    // Randomized stalls, redirects and memory latency.
    rand_lat = 1'b1;
    lat = 1;
    do_reset();
    n_new = 0;
    for (int i = 0; i < 1500; i++) begin
      tick();
      stall = ($urandom_range(0, 99) < 30);
      redirect = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else redirect_pc = $urandom;
      drive();
    end
    chk("progress", {31'd0, (n_new > 100)}, 32'd1);

    // Asynchronous reset in the middle of an outstanding request.
    rand_lat = 1'b0;
    lat = 2;
    for (int i = 0; i < 4; i++) begin tick(); quiet_cycle(); end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, fv}, 32'd0);
    chk("arst_pc", pc_out, 32'd0);
    chk("arst_ins", instruction, 32'd0);
    chk("arst_req", {31'd0, mem_if.imem_req_o}, 32'd0);
    chk("arst2_valid", {31'd0, fv2}, 32'd0);
    chk("arst2_pc", pc2, 32'd0);
    chk("arst2_ins", ins2, 32'd0);
    chk("arst2_req", {31'd0, mem2_if.imem_req_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that produces pc_out/instruction for the IF/ID pipeline register. It owns the PC, issues requests to instruction memory over a req/ack handshake and applies branch redirects from later stages. A one-entry skid register absorbs responses that arrive while ID is stalled, so zero-wait memory sustains one instruction per cycle. Bubbles are emitted as all-zero instructions, matching the IF/ID reset contents.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
PC_STEP, 4, byte increment between sequential fetches

Ports:
clk  in  1  clock, posedge; IF/ID samples outputs on negedge
rst  in  1  reset, asynchronous, active-high
stall_i  in  1  ID cannot accept; current output must be held
redirect_i  in  1  one-cycle pulse: flush and restart at redirect_pc_i
redirect_pc_i  in  32  redirect target; bits [1:0] forced to 0
imem_req_o  out  1  memory request valid
imem_addr_o  out  32  request address, word aligned
imem_ack_i  in  1  response valid; may assert in the same cycle as req
imem_rdata_i  in  32  instruction word, valid with ack
pc_out  out  32  PC of presented instruction
instruction  out  32  presented instruction; 32'h0 when invalid
fetch_valid  out  1  pc_out/instruction hold a real instruction

Behaviour:
- Reset (async): state=FETCH, fetch_pc=RESET_PC, pc_out=0, instruction=0, fetch_valid=0, skid empty. imem_req_o=0 while rst is high. The first request goes out in the first cycle after release.
- Consume rule: the output is consumed in any cycle with fetch_valid=1 and stall_i=0. slot_free = !fetch_valid || !stall_i.
- Handshake: while imem_req_o=1, imem_addr_o must stay stable until imem_ack_i. A request is never retracted, and at most one is outstanding.
- FETCH: req=1, addr=fetch_pc.
  - On ack with slot_free: next cycle pc_out=fetch_pc, instruction=rdata, fetch_valid=1, fetch_pc+=PC_STEP; stay in FETCH (back-to-back).
  - On ack with slot busy: rdata and fetch_pc go to skid, fetch_pc+=PC_STEP, go to SKID.
  - No ack: if slot_free then fetch_valid<=0 and instruction<=0 (bubble); otherwise hold.
- SKID: req=0; outputs held while stall_i=1. When stall_i=0, skid moves to the outputs next cycle and the state returns to FETCH.
- DRAIN: req=1 with the stale address. On ack the data is discarded and the state goes to FETCH; fetch_pc already holds the target.
- Redirect: priority over stall and over everything else.
  - Next cycle: fetch_valid=0, instruction=0, pc_out=0; skid cleared; fetch_pc=redirect_pc_i & ~3.
  - If a request is outstanding this cycle without ack, go to DRAIN; otherwise (ack this cycle, or in SKID) go to FETCH.
  - A redirect while in DRAIN updates the target and stays in DRAIN.
- Latency: zero-wait memory gives the instruction on the outputs 1 cycle after the req cycle. Redirect to the first target instruction valid is 2 cycles, plus the drain time if a request was outstanding.
- Wrap-around: fetch_pc 32'hFFFF_FFFC + 4 -> 32'h0000_0000, with no flag.
- Reset mid-transaction abandons the outstanding request; instruction memory shares rst.
- Invariant: fetch_valid=0 implies instruction=0.

Decomposition:
- Package fetch_pkg: state enum {FETCH, SKID, DRAIN}, NOP_INSTR=32'h0, PC_W=32.
- Sub-module fetch_skid_reg: one-entry pc+instr holding register with load/clear/valid, instantiated once.

Test Plan:
- Reset release, ack tied to req (zero wait) -> pc_out 0,4,8,12 on consecutive cycles, fetch_valid continuously 1, instruction equals memory contents.
- ack delayed 2 cycles per request -> each instruction valid for one cycle, then 2 bubble cycles with instruction=0; imem_addr_o stable while waiting.
- stall_i=1 for 3 cycles while pc_out=8 and a request is in flight -> outputs hold 8; pc 12 lands in skid, req=0; after release outputs 12 then 16, with nothing lost or duplicated.
- redirect_i with redirect_pc_i=32'h103 while the request for 0x20 is unacked (ack after 2 cycles):
  - Required: DRAIN discards 0x20.
  - Required: next request addr=0x100.
  - Required: pc_out=0x100 valid.
  - Required: no instruction from 0x20 ever appears with fetch_valid=1.
- redirect_i during SKID with stall_i=1 -> skid flushed, fetch_valid=0 next cycle regardless of stall, fetch resumes at target.
- RESET_PC=32'hFFFF_FFF8, zero wait -> pc_out FFFF_FFF8, FFFF_FFFC, 0000_0000; async rst asserted mid-request clears all outputs immediately.
